cpu_presser: RTL and testbench
==============================

# cpu_presser

Synthetic button-press generator for the automated opponent in the tug-of-war game. It produces single-cycle press pulses at a pseudo-random rate set by a 4-bit difficulty level. Its output drives the same downstream press-handling logic that a synchronized human button feeds. Because the pulses are generated inside the clock domain, no synchronizer stage is needed.

## Interface
Parameters:
- LFSR_W, 10, LFSR width. The feedback taps are fixed for 10, so only the value 10 is supported.
- HOLDOFF, 4, minimum number of idle cycles forced after each press. Must be in the range 1..15.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- enable, input, 1, run control. When low, the block is frozen and emits no presses.
- level, input, 4, difficulty level, unsigned. 0 means the block never presses; 15 is the most aggressive setting.
- press, output, 1, registered single-cycle press pulse.
- lfsr_q, output, LFSR_W, current LFSR state. Exposed for debug and verification.

## Operation
- The LFSR is a Fibonacci XNOR type, polynomial x^10 + x^7 + 1.
  - Feedback: fb = ~(lfsr_q[9] ^ lfsr_q[6]).
  - Next state: {lfsr_q[8:0], fb}.
  - The all-zero state is a legal state and is the reset value. The all-ones state (0x3FF) locks up, and it is unreachable from reset.
- The holdoff counter is internal, 4 bits wide, and resets to 0.
- On each rising clk edge, the first matching rule applies:
  - reset=1: lfsr_q <= 0, holdoff <= 0, press <= 0. This takes priority over all other inputs.
  - enable=0: press <= 0. lfsr_q and holdoff hold their values.
  - enable=1 and holdoff != 0: press <= 0, holdoff <= holdoff - 1, LFSR advances.
  - enable=1 and holdoff == 0: press <= (lfsr_q[3:0] < level), using an unsigned compare on the pre-edge values. If that compare is true, holdoff <= HOLDOFF. The LFSR advances.
- Press probability per eligible cycle is roughly level/16.
- Press pulses are one cycle wide. Consecutive rising edges of press are at least HOLDOFF+1 cycles apart.
- Toggling enable does not reset any state. Resuming continues the same sequence.

## Timing
- Reset values: press=0 and lfsr_q=0 take effect on the first edge with reset=1. There are no asynchronous paths.
- Latency: press is registered and reflects the lfsr_q, holdoff, level and enable values present before the edge.
- level is sampled every cycle. A change affects the compare on the next edge.
- Reset asserted in the middle of a holdoff window clears the window. The first eligible compare follows on the first edge with reset=0 and enable=1.
- Pressing on consecutive cycles is impossible because HOLDOFF >= 1.
- LFSR sequence from reset, with enable held high: 0x000, 0x001, 0x003, 0x007, 0x00F, 0x01F, 0x03F, 0x07F, 0x0FE, and so on.

## Test plan
- Reset to level 15: hold reset for 2 edges, then release with enable=1 and level=15.
  - press is high only after edges 1 and 9, and low after edges 2 through 8.
  - lfsr_q reads 0x0FE after edge 8.
- Level 1: after reset, set enable=1 and level=1.
  - press is high after edge 1, since nibble 0 < 1.
  - press is then low through edge 8, since the nibbles are 1, 3, 7, F, F, F, F, E.
- Level 0: enable=1 and level=0 for 2000 cycles.
  - press stays low throughout.
  - lfsr_q never reads 0x3FF.
- Enable gating: at lfsr_q=0x007, drop enable for 5 edges, then raise it again.
  - While enable is low, press=0 and lfsr_q stays 0x007.
  - On the first edge after enable returns, lfsr_q becomes 0x00F.
- Reset mid-holdoff: with level=15, assert reset on edge 2, directly after the first press. Release reset, enable=1.
  - After the reset edge, press=0 and lfsr_q=0.
  - press is high after the first edge following release.
- Spacing: with level=15 and enable=1 for 5000 cycles, a scoreboard checks that every press pulse is 1 cycle wide and the gap between press pulses is >= 5 cycles.

Source files
------------

// File: rtl/cpu_presser.sv
// cpu_presser: synthetic button-press generator for the automated opponent
// in the tug-of-war game. A 10-bit XNOR LFSR supplies a pseudo-random nibble
// that is compared against the difficulty level. A hit produces a one-cycle
// press pulse, and a holdoff window then blocks further presses for HOLDOFF
// cycles. The pulses come from inside the clock domain, so the downstream
// press logic needs no synchronizer for this source.
//
// Parameters:
//   LFSR_W  - LFSR width; the feedback taps are fixed for 10 bits.
//   HOLDOFF - idle cycles forced after each press (1..15).
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset
//   enable  in   run control; low freezes all state and suppresses presses
//   level   in   4-bit difficulty; 0 never presses, 15 is most aggressive
//   press   out  registered single-cycle press pulse
//   lfsr_q  out  current LFSR state (debug/verification)

module cpu_presser #(
  parameter int LFSR_W  = 10,
  parameter int HOLDOFF = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        level,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam logic [3:0] HOLDOFF_V = 4'(HOLDOFF);

  // XNOR feedback for x^10 + x^7 + 1. The all-zero state is legal, so the
  // reset value of zero is safe. 0x3FF is the lock-up state and cannot be
  // reached from zero.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] cur);
    logic fb;
    fb = ~(cur[9] ^ cur[6]);
    return {cur[LFSR_W-2:0], fb};
  endfunction

  logic [3:0]        holdoff_r;
  logic [3:0]        holdoff_next_s;
  logic [LFSR_W-1:0] lfsr_next_s;
  logic              press_next_s;
  logic              hit_s;

  // Compare the low nibble of the current LFSR state against the level.
  always_comb begin
    hit_s = (lfsr_q[3:0] < level);
  end

  // Next-state logic for the LFSR, the holdoff window and the press pulse.
  always_comb begin
    press_next_s   = 1'b0;
    holdoff_next_s = holdoff_r;
    lfsr_next_s    = lfsr_q;
    if (!enable) begin
      // Frozen: hold all state so that resuming continues the same sequence.
      press_next_s   = 1'b0;
      holdoff_next_s = holdoff_r;
      lfsr_next_s    = lfsr_q;
    end else if (holdoff_r != 4'd0) begin
      // Inside the holdoff window: count down, keep the LFSR moving.
      press_next_s   = 1'b0;
      holdoff_next_s = holdoff_r - 4'd1;
      lfsr_next_s    = lfsr_advance(lfsr_q);
    end else begin
      press_next_s = hit_s;
      if (hit_s) begin
        holdoff_next_s = HOLDOFF_V;
      end else begin
        holdoff_next_s = 4'd0;
      end
      lfsr_next_s = lfsr_advance(lfsr_q);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q    <= '0;
      holdoff_r <= 4'd0;
      press     <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_next_s;
      holdoff_r <= holdoff_next_s;
      press     <= press_next_s;
    end
  end

endmodule

// File: tb/tb_cpu_presser.sv
// tb_cpu_presser: self-checking bench for cpu_presser. A behavioural model
// tracks the LFSR value and the number of enabled cycles since the last
// press; a negedge process compares the DUT against it every cycle. Directed
// scenarios pin the model with hand-computed literal values, and a random
// phase exercises enable, level and reset together.

module tb_cpu_presser;

  localparam int HOLDOFF = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] level;
  logic       press;
  logic [9:0] lfsr_q;

  int tests = 0;
  int fails = 0;

  cpu_presser #(.LFSR_W(10), .HOLDOFF(HOLDOFF)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .level  (level),
    .press  (press),
    .lfsr_q (lfsr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: shift left, feed in XNOR of bits 9 and 6.
  function automatic logic [9:0] model_next(input logic [9:0] x);
    int v;
    int fb;
    v  = int'(x);
    fb = (((v >> 9) & 1) == ((v >> 6) & 1)) ? 1 : 0;
    return 10'(((v * 2) % 1024) + fb);
  endfunction

  // Model state: a press is allowed once HOLDOFF enabled cycles have passed
  // since the previous press (reset makes it immediately eligible).
  logic [9:0] m_lfsr;
  logic       m_press;
  int         m_since;
  bit         check_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_lfsr  <= 10'd0;
      m_press <= 1'b0;
      m_since <= 1000;
    end else if (!enable) begin
      m_press <= 1'b0;
    end else begin
      m_lfsr <= model_next(m_lfsr);
      if (m_since >= HOLDOFF && int'(m_lfsr % 10'd16) < int'(level)) begin
        m_press <= 1'b1;
        m_since <= 0;
      end else begin
        m_press <= 1'b0;
        m_since <= (m_since >= 1000) ? 1000 : m_since + 1;
      end
    end
  end

  // Compare the DUT against the model on every cycle.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_press", 32'(press), 32'(m_press));
      check("model_lfsr", 32'(lfsr_q), 32'(m_lfsr));
      check("no_lockup", 32'(lfsr_q == 10'h3FF), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    int npress;
    int gap;
    bit prev;
    bit seen;

    reset  = 1'b1;
    enable = 1'b0;
    level  = 4'd0;
    tick(2);
    check_en = 1'b1;
    check("reset_press", 32'(press), 32'd0);
    check("reset_lfsr", 32'(lfsr_q), 32'h000);

    // Level 15 from reset: presses after edges 1 and 9 only.
    reset  = 1'b0;
    enable = 1'b1;
    level  = 4'd15;
    tick(1);
    check("l15_e1_press", 32'(press), 32'd1);
    for (int e = 2; e <= 9; e++) begin
      tick(1);
      check("l15_press", 32'(press), (e == 9) ? 32'd1 : 32'd0);
      if (e == 8) check("l15_lfsr_e8", 32'(lfsr_q), 32'h0FE);
    end

    // Level 1: only nibble 0 presses.
    do_reset();
    enable = 1'b1;
    level  = 4'd1;
    tick(1);
    check("l1_e1_press", 32'(press), 32'd1);
    for (int e = 2; e <= 9; e++) begin
      tick(1);
      check("l1_press", 32'(press), 32'd0);
    end

    // Level 0: never presses.
    do_reset();
    enable = 1'b1;
    level  = 4'd0;
    npress = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (press) npress++;
    end
    check("l0_press_count", 32'(npress), 32'd0);

    // Enable gating at lfsr_q = 0x007.
    do_reset();
    enable = 1'b1;
    level  = 4'd8;
    tick(3);
    check("gate_lfsr_start", 32'(lfsr_q), 32'h007);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("gate_press", 32'(press), 32'd0);
      check("gate_lfsr_hold", 32'(lfsr_q), 32'h007);
    end
    enable = 1'b1;
    tick(1);
    check("gate_lfsr_resume", 32'(lfsr_q), 32'h00F);

    // Reset in the middle of a holdoff window.
    do_reset();
    enable = 1'b1;
    level  = 4'd15;
    tick(1);
    check("rmid_first_press", 32'(press), 32'd1);
    reset = 1'b1;
    tick(1);
    check("rmid_reset_press", 32'(press), 32'd0);
    check("rmid_reset_lfsr", 32'(lfsr_q), 32'h000);
    reset = 1'b0;
    tick(1);
    check("rmid_release_press", 32'(press), 32'd1);

    // Spacing scoreboard at level 15.
    do_reset();
    enable = 1'b1;
    level  = 4'd15;
    prev   = 1'b0;
    seen   = 1'b0;
    gap    = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      gap++;
      if (press && prev) check("spacing_width", 32'd2, 32'd1);
      if (press && !prev) begin
        if (seen) check("spacing_gap_ok", 32'(gap >= HOLDOFF + 1), 32'd1);
        seen = 1'b1;
        gap  = 0;
      end
      prev = press;
    end
    check("spacing_saw_press", 32'(seen), 32'd1);

    // Randomized enable / level / reset against the model.
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 9) != 0);
      level  = 4'($urandom_range(0, 15));
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
